add_sequencer: RTL
==================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-high):
  clk  input  1  sole clock, rising edge
  reset  input  1  asynchronous, active-high
  start_valid  input  1  operation request
  start_ready  output  1  sequencer can accept request
  op_a  input  W  first operand
  op_b  input  W  second operand
  op_sub  input  1  1 = a-b, 0 = a+b (ignored unless SUB_EN)
  add_a  output  4  nibble to Adder4b a
  add_b  output  4  nibble to Adder4b b
  add_cin  output  1  carry to Adder4b c_in
  add_s  input  4  Adder4b sum, combinational
  add_cout  input  1  Adder4b carry out, combinational
  res_valid  output  1  result available
  res_ready  input  1  consumer takes result
  result  output  W  sum/difference
  carry_out  output  1  final carry (sub: 1 = no borrow)
  overflow  output  1  two's-complement overflow
  busy  output  1  high in RUN or DONE

Function
REQ-003 SHALL implement FSM IDLE, RUN, DONE; start_ready = (state==IDLE); res_valid = (state==DONE).
REQ-004 In IDLE, start_valid=1 SHALL latch op_a, op_b (op_b bitwise-inverted if effective sub), clear nibble index to 0, set carry register to effective sub, and enter RUN at the same edge.
REQ-005 In RUN, add_a/add_b SHALL present latched nibble [index], add_cin the carry register.
REQ-006 Each RUN edge SHALL write add_s into result nibble [index] and add_cout into carry register; index increments.
REQ-007 Edge at index==NIBBLES-1 SHALL enter DONE; RUN lasts exactly NIBBLES cycles; acceptance at edge k gives res_valid high after edge k+NIBBLES.
REQ-008 carry_out SHALL equal final add_cout; overflow SHALL be 1 iff latched a MSB equals latched (possibly inverted) b MSB and result MSB differs, registered at the last RUN edge.
REQ-009 In DONE, result/carry_out/overflow SHALL hold stable; res_ready=1 SHALL return to IDLE at that edge.
REQ-010 start_valid SHALL be ignored outside IDLE; a request arriving with the DONE->IDLE edge is accepted no earlier than the next edge.
REQ-011 Outside RUN, add_a, add_b, add_cin SHALL be 0.
REQ-012 result/carry_out/overflow SHALL keep last values in IDLE until the next RUN overwrites them.

Reset
REQ-013 reset SHALL immediately force IDLE, index 0, carry register 0, result 0, carry_out 0, overflow 0, operand latches 0, regardless of clk.
REQ-014 reset during RUN or DONE SHALL abandon the operation; no res_valid pulse for it; start_ready=1 on the first edge after deassertion.

Configuration
REQ-015 With SUB_EN defined, effective sub = op_sub sampled at acceptance (invert b, initial carry 1).
REQ-016 Without SUB_EN, effective sub SHALL be constant 0, op_sub unused, no inversion logic synthesized.

Verification
REQ-017 0x1234 + 0x4321 -> result 0x5555, carry_out 0, overflow 0, res_valid exactly 4 cycles after acceptance.
REQ-018 0xFFFF + 0x0001 -> result 0x0000, carry_out 1, overflow 0; add_cin sequence 0,1,1,1.
REQ-019 0x7FFF + 0x0001 -> result 0x8000, carry_out 0, overflow 1.
REQ-020 SUB_EN: 0x0005 - 0x0007 -> 0xFFFE, carry_out 0, overflow 0; 0x8000 - 0x0001 -> 0x7FFF, overflow 1.
REQ-021 res_ready low 3 cycles in DONE -> res_valid, result held; start_valid pulses ignored; IDLE one edge after res_ready=1.
REQ-022 reset asserted during RUN 2nd cycle -> outputs 0, IDLE, start_ready 1; next 0x0001+0x0001 -> 0x0002.

Source files
------------

// File: rtl/add_sequencer.sv
// add_sequencer: serial W-bit add (optionally subtract) built around one
// external combinational 4-bit adder (Adder4b). Operands are latched on
// acceptance, then one nibble per cycle is pushed through the adder, LSB
// nibble first, with the carry kept in a register between cycles.
//
// Optional feature: define SUB_EN to enable subtraction (op_sub selects
// a-b by inverting b and seeding the carry with 1). Without SUB_EN the
// block only adds and op_sub is ignored.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   start_valid/ready     request handshake; op_a, op_b, op_sub operands
//   add_a/b/cin           drive to the external Adder4b
//   add_s/cout            combinational result back from Adder4b
//   res_valid/ready       result handshake; result, carry_out, overflow
//   busy                  high while an operation is in RUN or DONE
module add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_sub,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic [NIBBLES-1:0][3:0]   a_q, a_d;
  logic [NIBBLES-1:0][3:0]   b_q, b_d;
  logic [NIBBLES-1:0][3:0]   res_q, res_d;
  logic                      cout_q, cout_d;
  logic                      ovf_q, ovf_d;

  // Effective subtract and the b operand as it gets latched.
  logic                      eff_sub;
  logic [4*NIBBLES-1:0]      b_in;

`ifdef SUB_EN
  assign eff_sub = op_sub;
  assign b_in    = op_sub ? ~op_b : op_b;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign eff_sub       = 1'b0;
  assign b_in          = op_b;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = b_in;
          idx_d   = '0;
          carry_d = eff_sub;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q] = add_s;
        carry_d      = add_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = add_cout;
          // Operand signs agree but the result sign (MSB of the last
          // nibble, being written now) differs.
          ovf_d   = (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                    (add_s[3] != a_q[NIBBLES-1][3]);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE);
    busy        = (state_q == RUN) || (state_q == DONE);
    add_a       = 4'h0;
    add_b       = 4'h0;
    add_cin     = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[idx_q];
      add_b   = b_q[idx_q];
      add_cin = carry_q;
    end
  end

  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule
